branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor for the 5-stage core: direct-mapped BTB + 2-bit counter PHT, sits beside stage_fetch.
//  Fetch PC is looked up combinationally; predicted next PC feeds fetch, replacing the fixed static not-taken path.
//  Resolved branches/jumps from EXMEM train the tables one cycle later.
//  Mispredict flush stays in the core; this block only predicts and learns.
// PARAMETERS
//  XLEN      32  address/data width
//  ENTRIES   64  BTB and PHT depth; power of two, >=4; IDX_W=$clog2(ENTRIES)
//  GHR_W      6  global history bits; used only with BP_GSHARE_EN; must be <= IDX_W
// PORTS
//  clk                 in   1     clock, all state on rising edge
//  reset               in   1     asynchronous, active-low (0 = reset)
//  in_fetch_PC         in   XLEN  PC being fetched this cycle
//  out_predict_taken   out  1     1 = redirect fetch to out_predict_PC
//  out_predict_PC      out  XLEN  predicted next PC (target if taken, else in_fetch_PC+4)
//  in_update_valid     in   1     resolved control-flow instruction in EXMEM this cycle
//  in_update_PC        in   XLEN  PC of resolved instruction
//  in_update_taken     in   1     actual direction
//  in_update_target    in   XLEN  actual target address
//  in_update_uncond    in   1     1 = JAL/JALR (always taken)
// BEHAVIOUR
//  - Index bits PC[IDX_W+1:2]; tag PC[XLEN-1:IDX_W+2]. BTB entry = {valid, tag, target}. PHT entry = 2-bit sat counter.
//  - Lookup (comb, 0 cycles): hit = valid & tag match; out_predict_taken = hit & PHT[pidx][1].
//    out_predict_PC = out_predict_taken ? BTB.target : in_fetch_PC+4 (mod 2^XLEN, wraps silently).
//  - Update (posedge, in_update_valid=1), bidx = index(in_update_PC):
//    hit & uncond  -> counter=2'b11, target overwritten
//    hit & taken   -> counter=min(c+1,3), target overwritten
//    hit & !taken  -> counter=max(c-1,0), target kept
//    miss & taken  -> allocate: valid=1, tag, target; counter=2'b10 (uncond: 2'b11); evicts old entry
//    miss & !taken -> no change
//  - in_update_valid=0: no state change.
//  - Same-cycle lookup and update of same index: lookup sees pre-update contents (no bypass).
//  - Reset (async assert, sync to clk on deassert via core): all valid=0, all counters=2'b01, GHR=0.
//    Outputs while/after reset: out_predict_taken=0, out_predict_PC=in_fetch_PC+4.
//  - Reset mid-update: update discarded; tables fully cleared.
//  - Out-of-range parameters rejected by elaboration-time $error.
// CONFIGURATION
//  BP_GSHARE_EN defined: GHR_W-bit global history register; PHT index = PC index XOR zero-extended GHR
//    (both lookup and update use current GHR). On update of conditional branch (uncond=0) GHR <= {GHR[GHR_W-2:0], taken}.
//    GHR is non-speculative (training-time only). BTB still indexed by PC only.
//  BP_GSHARE_EN undefined: no GHR flops; PHT index = BTB index (bimodal).
// STRUCTURE
//  bp_pkg: counter encodings STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
//    btb_entry_t struct parametrised via XLEN/tag width; sat_inc/sat_dec functions.
//  Sub-module bp_pht: counter array + GHR + index hashing (one read port, one write port).
//  BTB array, tag compare and next-PC mux in branch_predictor top.
// TESTING
//  1 Reset then in_fetch_PC=0x100 -> out_predict_taken=0, out_predict_PC=0x104.
//  2 Update PC=0x100 taken target=0x200 -> next cycle fetch 0x100 gives taken=1, PC=0x200 (counter WEAK_T).
//  3 Then two not-taken updates of 0x100 -> after first: taken=0 (WEAK_NT); after second: STRONG_NT; target retained.
//  4 Alias: train 0x100 (ENTRIES=64) then update 0x200 taken target=0x300 -> fetch 0x100 misses, taken=0, PC=0x104.
//  5 Lookup and update of 0x100 in same cycle -> that cycle shows old prediction, following cycle new.
//  6 BP_GSHARE_EN, GHR_W=2: pattern T,NT alternating at PC 0x40 for 16 updates -> final 4 predictions match actual.
//    Also: assert reset=0 mid-training -> predictor returns to not-taken for all PCs.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared predictor types: 2-bit counter encodings, saturating helpers, BTB entry layout, PHT update ops.
// No state and no handshake here; imported by branch_predictor and bp_pht.
package bp_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Layout of one BTB row at the default core configuration (32-bit PC, 64 entries).
  localparam int BP_XLEN  = 32;
  localparam int BP_IDX_W = 6;
  localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

  typedef struct packed {
    logic                vld;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  tgt;
  } btb_entry_t;

  typedef enum logic [2:0] {
    PHT_NOP,
    PHT_INC,
    PHT_DEC,
    PHT_SET_WT,
    PHT_SET_ST
  } pht_op_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == STRONG_T) ? STRONG_T : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of 2-bit counters; read is combinational, update lands on the next rising edge.
// No backpressure. BP_GSHARE_EN adds a training-time global history XORed into both indices.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int GHR_W   = 6,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_upd_vld,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  pht_op_e          i_upd_op,
  input  logic             i_upd_cond,
  input  logic             i_upd_taken
);

  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr
    $error("bp_pht: GHR_W must be in 1..IDX_W");
  end

  logic [1:0]       r_cnt [ENTRIES];
  logic [IDX_W-1:0] w_rd_pidx;
  logic [IDX_W-1:0] w_wr_pidx;
  logic [1:0]       w_wr_cnt;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  assign w_rd_pidx = i_rd_idx ^ IDX_W'(r_ghr);
  assign w_wr_pidx = i_upd_idx ^ IDX_W'(r_ghr);

  // History only advances on resolved conditional branches, never speculatively.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (i_upd_vld && i_upd_cond) begin
      r_ghr <= GHR_W'({r_ghr, i_upd_taken});
    end
  end
`else
  logic w_unused_hist;

  assign w_unused_hist = i_upd_cond ^ i_upd_taken;
  assign w_rd_pidx     = i_rd_idx;
  assign w_wr_pidx     = i_upd_idx;
`endif

  assign o_rd_cnt = r_cnt[w_rd_pidx];

  always_comb begin
    w_wr_cnt = r_cnt[w_wr_pidx];
    unique case (i_upd_op)
      PHT_INC:    w_wr_cnt = sat_inc(r_cnt[w_wr_pidx]);
      PHT_DEC:    w_wr_cnt = sat_dec(r_cnt[w_wr_pidx]);
      PHT_SET_WT: w_wr_cnt = WEAK_T;
      PHT_SET_ST: w_wr_cnt = STRONG_T;
      default:    w_wr_cnt = r_cnt[w_wr_pidx];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= WEAK_NT;
      end
    end else if (i_upd_vld && (i_upd_op != PHT_NOP)) begin
      r_cnt[w_wr_pidx] <= w_wr_cnt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit PHT next-PC predictor beside fetch; lookup is combinational, training lands one edge later.
// No backpressure: every update is accepted. Define BP_GSHARE_EN for gshare PHT indexing (bimodal otherwise).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int GHR_W   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] in_fetch_PC,
  output logic            out_predict_taken,
  output logic [XLEN-1:0] out_predict_PC,
  input  logic            in_update_valid,
  input  logic [XLEN-1:0] in_update_PC,
  input  logic            in_update_taken,
  input  logic [XLEN-1:0] in_update_target,
  input  logic            in_update_uncond
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  if (ENTRIES < 4 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two and >= 4");
  end
  if (TAG_W < 1) begin : g_bad_xlen
    $error("branch_predictor: XLEN too small for ENTRIES");
  end

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  tgt;
  } btb_row_t;

  btb_row_t r_btb [ENTRIES];

  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  btb_row_t         w_fetch_row;
  logic             w_fetch_hit;
  logic [1:0]       w_fetch_cnt;

  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  btb_row_t         w_upd_row;
  logic             w_upd_hit;
  logic             w_upd_taken;
  pht_op_e          w_pht_op;
  logic             w_unused_upd_lsb;

  assign w_fetch_idx = in_fetch_PC[IDX_W+1:2];
  assign w_fetch_tag = in_fetch_PC[XLEN-1:IDX_W+2];
  assign w_fetch_row = r_btb[w_fetch_idx];
  assign w_fetch_hit = w_fetch_row.vld && (w_fetch_row.tag == w_fetch_tag);

  assign out_predict_taken = w_fetch_hit & w_fetch_cnt[1];
  assign out_predict_PC    = out_predict_taken ? w_fetch_row.tgt : in_fetch_PC + XLEN'(4);

  assign w_upd_idx        = in_update_PC[IDX_W+1:2];
  assign w_upd_tag        = in_update_PC[XLEN-1:IDX_W+2];
  assign w_upd_row        = r_btb[w_upd_idx];
  assign w_upd_hit        = w_upd_row.vld && (w_upd_row.tag == w_upd_tag);
  assign w_upd_taken      = in_update_taken | in_update_uncond;
  assign w_unused_upd_lsb = ^in_update_PC[1:0];

  always_comb begin
    w_pht_op = PHT_NOP;
    if (w_upd_hit) begin
      if (in_update_uncond)     w_pht_op = PHT_SET_ST;
      else if (in_update_taken) w_pht_op = PHT_INC;
      else                      w_pht_op = PHT_DEC;
    end else if (w_upd_taken) begin
      w_pht_op = in_update_uncond ? PHT_SET_ST : PHT_SET_WT;
    end
  end

  // A taken outcome either refreshes the target of a hit or evicts whatever lived at this index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i] <= '0;
      end
    end else if (in_update_valid && w_upd_taken) begin
      r_btb[w_upd_idx] <= '{vld: 1'b1, tag: w_upd_tag, tgt: in_update_target};
    end
  end

  bp_pht #(
    .ENTRIES (ENTRIES),
    .GHR_W   (GHR_W)
  ) u_pht (
    .clk         (clk),
    .rst_n       (reset),
    .i_rd_idx    (w_fetch_idx),
    .o_rd_cnt    (w_fetch_cnt),
    .i_upd_vld   (in_update_valid),
    .i_upd_idx   (w_upd_idx),
    .i_upd_op    (w_pht_op),
    .i_upd_cond  (~in_update_uncond),
    .i_upd_taken (in_update_taken)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expectations are queued when a fetch is driven and checked mid-cycle.
// Build with BP_GSHARE_EN to exercise the global-history indexing instead of the bimodal cases.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] in_fetch_PC;
  logic        out_predict_taken;
  logic [31:0] out_predict_PC;
  logic        in_update_valid;
  logic [31:0] in_update_PC;
  logic        in_update_taken;
  logic [31:0] in_update_target;
  logic        in_update_uncond;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];

  branch_predictor #(
    .XLEN    (32),
    .ENTRIES (64),
    .GHR_W   (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_fetch_PC       (in_fetch_PC),
    .out_predict_taken (out_predict_taken),
    .out_predict_PC    (out_predict_PC),
    .in_update_valid   (in_update_valid),
    .in_update_PC      (in_update_PC),
    .in_update_taken   (in_update_taken),
    .in_update_target  (in_update_target),
    .in_update_uncond  (in_update_uncond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive fetch + optional update after the edge, check the lookup mid-cycle.
  // The update commits on the following rising edge.
  task automatic run_cycle(input string tag, input logic [31:0] fpc, input logic chk_en,
                           input logic exp_taken, input logic [31:0] exp_pc,
                           input logic uv, input logic [31:0] upc, input logic ut,
                           input logic [31:0] utgt, input logic uu);
    exp_t e;
    @(posedge clk);
    #1;
    in_fetch_PC      = fpc;
    in_update_valid  = uv;
    in_update_PC     = upc;
    in_update_taken  = ut;
    in_update_target = utgt;
    in_update_uncond = uu;
    if (chk_en) begin
      e.tag   = tag;
      e.taken = exp_taken;
      e.pc    = exp_pc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (chk_en) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check({e.tag, "_taken"}, {31'd0, out_predict_taken}, {31'd0, e.taken});
        check({e.tag, "_pc"}, out_predict_PC, e.pc);
      end
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] fpc, input logic exp_taken,
                       input logic [31:0] exp_pc);
    run_cycle(tag, fpc, 1'b1, exp_taken, exp_pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic update(input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic uu);
    run_cycle("upd", 32'h0, 1'b0, 1'b0, 32'd0, 1'b1, upc, ut, utgt, uu);
  endtask

  initial begin
    reset            = 1'b0;
    in_fetch_PC      = 32'h0;
    in_update_valid  = 1'b0;
    in_update_PC     = 32'h0;
    in_update_taken  = 1'b0;
    in_update_target = 32'h0;
    in_update_uncond = 1'b0;

    fetch("in_reset", 32'h100, 1'b0, 32'h104);
    @(posedge clk);
    #1 reset = 1'b1;

    fetch("post_reset", 32'h100, 1'b0, 32'h104);
    fetch("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

`ifdef BP_GSHARE_EN
    // Alternating T,NT at 0x40: with two history bits each outcome gets its own counter.
    for (int k = 0; k < 16; k++) begin
      logic t;
      t = (k % 2) == 0;
      run_cycle($sformatf("gshare_%0d", k), 32'h40, k >= 12, t, t ? 32'h80 : 32'h44,
                1'b1, 32'h40, t, 32'h80, 1'b0);
    end
`else
    // Allocate 0x100 while looking up an unrelated PC.
    run_cycle("alloc_other", 32'h104, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    fetch("weak_t", 32'h100, 1'b1, 32'h200);
    fetch("tag_miss", 32'h4100, 1'b0, 32'h4104);

    // Same-cycle lookup and not-taken update: lookup still sees WEAK_T.
    run_cycle("same_cycle_old", 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    fetch("weak_nt", 32'h100, 1'b0, 32'h104);
    update(32'h100, 1'b0, 32'h0, 1'b0);
    fetch("strong_nt", 32'h100, 1'b0, 32'h104);
    // From STRONG_NT one taken only reaches WEAK_NT; a second one predicts taken.
    update(32'h100, 1'b1, 32'h280, 1'b0);
    fetch("after_1_taken", 32'h100, 1'b0, 32'h104);
    update(32'h100, 1'b1, 32'h280, 1'b0);
    fetch("after_2_taken", 32'h100, 1'b1, 32'h280);

    // Alias at index 0 evicts 0x100.
    update(32'h200, 1'b1, 32'h300, 1'b0);
    fetch("alias_evicted", 32'h100, 1'b0, 32'h104);
    fetch("alias_new", 32'h200, 1'b1, 32'h300);

    // Jump allocates STRONG_T: survives one not-taken, falls on the second.
    update(32'h140, 1'b1, 32'h400, 1'b1);
    fetch("uncond", 32'h140, 1'b1, 32'h400);
    update(32'h140, 1'b0, 32'h0, 1'b0);
    fetch("strong_t_dec", 32'h140, 1'b1, 32'h400);
    update(32'h140, 1'b0, 32'h0, 1'b0);
    fetch("weak_t_dec", 32'h140, 1'b0, 32'h144);

    // Update fields without valid must not train.
    run_cycle("no_valid", 32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h180, 1'b1, 32'h500, 1'b0);
    fetch("no_valid_chk", 32'h180, 1'b0, 32'h184);
`endif

    // Reset asserted while an update is being presented: tables clear, update discarded.
    run_cycle("midreset_upd", 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 32'h90, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_midreset_taken", {31'd0, out_predict_taken}, 32'd0);
    @(posedge clk);
    #1;
    reset           = 1'b1;
    in_update_valid = 1'b0;
    fetch("rst_clr_40", 32'h40, 1'b0, 32'h44);
    fetch("rst_clr_140", 32'h140, 1'b0, 32'h144);
    fetch("rst_clr_200", 32'h200, 1'b0, 32'h204);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
